div_tick_arbiter: RTL and testbench
===================================

# div_tick_arbiter

Downstream consumer of the multi-channel frequency divider bank. Takes the `NB_DIV` divided-clock lines, which are all derived from `ClkIn`, and samples them in the `ClkIn` domain. It detects rising edges and records a per-channel pending event with a timestamp. It then serialises the events through a round-robin arbiter onto a single valid/ready event stream consumed by the SDRAM HAL control logic.

## Interface
Parameters:
- `NB_DIV`, 24 — number of divided-clock channels; must match the divider bank.
- `STAMP_W`, 16 — width of the free-running timestamp counter.
- `CHAN_W`, 5 — width of the channel index; must satisfy 2^`CHAN_W` ≥ `NB_DIV`.

Ports:
- `ClkIn`  in  1  — single clock for all logic.
- `Reset`  in  1  — asynchronous, active-high reset.
- `DivIn`  in  `NB_DIV`  — divided-clock lines from the divider bank, synchronous to `ClkIn`.
- `EvValid`  out  1  — an event is presented on `EvChan`/`EvStamp`.
- `EvReady`  in  1  — the consumer accepts the event.
- `EvChan`  out  `CHAN_W`  — channel index of the presented event.
- `EvStamp`  out  `STAMP_W`  — timestamp of the rising edge.
- `Ovf`  out  `NB_DIV`  — sticky per-channel overflow flags.
- `OvfClr`  in  `NB_DIV`  — per-channel overflow clear pulses.

## Operation
- Edge detect:
  - `DivQ` <= `DivIn`, then `DivQQ` <= `DivQ`.
  - `Rise[i]` = `DivQ[i] & ~DivQQ[i]`.
  - Only rising edges create events.
- Timestamp:
  - `Stamp` increments by 1 every cycle and wraps modulo 2^`STAMP_W`.
  - On `Rise[i]`, the current `Stamp` is stored in `ChStamp[i]` and `Pend[i]` is set.
- Collision:
  - If `Rise[i]` occurs while `Pend[i]` = 1 and channel i is not being granted this cycle, `Ovf[i]` is set.
  - `ChStamp[i]` keeps the older value and the new edge is dropped.
- Grant:
  - Output slot is loadable when `EvValid` = 0, or `EvValid & EvReady` = 1.
  - When loadable and any `Pend` bit is set, the round-robin arbiter picks the first pending channel strictly after the last granted channel, searching upward and wrapping at `NB_DIV`-1 to 0.
  - The grant loads `EvChan` and `EvStamp`, sets `EvValid`, and clears the granted channel's `Pend` bit.
- Simultaneous grant and rise on the same channel:
  - The grant takes the old stamp.
  - `Pend` stays set, holding the new stamp.
  - No overflow is flagged.
- Overflow clear:
  - `OvfClr[i]` clears `Ovf[i]`.
  - If set and clear occur in the same cycle, set wins.
- Handshake:
  - `EvChan`/`EvStamp` are held stable while `EvValid` is high and `EvReady` is low.
  - `EvValid` drops only after acceptance with no pending channel.

## Timing
- Reset values:
  - `DivQ` and `DivQQ` reset to all ones, so a line that is high at reset release causes no spurious event.
  - `Stamp`, `Pend`, `ChStamp`, `Ovf`, `EvValid`, `EvChan`, `EvStamp`, and the last-grant pointer (`NB_DIV`-1) reset to 0 / their stated values.
- Latency, with `DivIn[i]` first high at sampling edge k:
  - `Rise[i]` is true in cycle k..k+1.
  - `Pend[i]` is set at edge k+1 with `ChStamp[i]` = `Stamp` value during that cycle.
  - With an idle output slot, `EvValid` is asserted at edge k+2.
- Throughput: one event per cycle while `EvReady` is held high.
- Accept and reload in the same cycle: a back-to-back event appears with no bubble.
- Reset mid-operation: all pending events, the presented event and overflow flags are discarded immediately (asynchronous).

## Structure
- Shared package `div_tick_pkg`:
  - `CHAN_W` derivation constant.
  - Channel-index typedef.
  - Default `NB_DIV`/`STAMP_W` constants shared with the divider bank.
- One sub-module, `rr_arbiter`:
  - Parameterised by `NB_DIV`.
  - Inputs: request vector, last-grant pointer.
  - Outputs: grant index and any-grant flag. Purely combinational.
  - Pointer register stays in the parent.

## Test plan
- Reset release with `DivIn` all ones, held 20 cycles -> `EvValid` stays 0 and `Ovf` = 0.
- Single rise on channel 3 at sampling edge 10, `EvReady` = 1 -> `EvValid` at edge 12, `EvChan` = 3, `EvStamp` = 10 (counting from reset), one-cycle pulse.
- Rises on channels 0, 5, 23 in the same cycle, `EvReady` = 1 -> events on consecutive cycles in order 0, 5, 23 with identical stamps; the next simultaneous burst on 0 and 5 is granted 0 then 5 after the pointer wraps.
- `EvReady` = 0 for 10 cycles with channel 7 presented -> `EvChan`/`EvStamp` stable; a second rise on 7 sets `Pend`, a third sets `Ovf[7]`; assert `OvfClr[7]` -> `Ovf[7]` = 0.
- `OvfClr[2]` in the same cycle as an overflow on channel 2 -> `Ovf[2]` remains 1.
- Full divider bank running, all lines at divide-by-48 with varied phase, for 10000 cycles -> no `Ovf`, every edge reported exactly once, stamps monotonic per channel modulo 2^16.

Source files
------------

// File: rtl/div_tick_pkg.sv
// Constants and types shared between the divider bank and the tick arbiter.
package div_tick_pkg;

  localparam int NB_DIV_DEF  = 24;
  localparam int STAMP_W_DEF = 16;

  // Channel index width; at least one bit even for a single channel.
  function automatic int chanWidth(input int nbDiv);
    return (nbDiv > 1) ? $clog2(nbDiv) : 1;
  endfunction

  localparam int CHAN_W_DEF = chanWidth(NB_DIV_DEF);

  typedef logic [CHAN_W_DEF-1:0] chanIdx_t;

endpackage

// File: rtl/div_tick_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after lastPtr,
// searching upward and wrapping from NB_DIV-1 to 0.
module rr_arbiter
  import div_tick_pkg::*;
#(
  parameter int NB_DIV = NB_DIV_DEF,
  parameter int CHAN_W = chanWidth(NB_DIV)
) (
  input  logic [NB_DIV-1:0] req,
  input  logic [CHAN_W-1:0] lastPtr,
  output logic [CHAN_W-1:0] grantIdx,
  output logic              anyGrant
);

  int idx;

  // Scan from the farthest offset down to 1 so the nearest requester wins;
  // offset NB_DIV is lastPtr itself, the lowest priority.
  always_comb begin
    grantIdx = '0;
    anyGrant = 1'b0;
    idx      = 0;
    for (int off = NB_DIV; off >= 1; off--) begin
      idx = (int'(lastPtr) + off) % NB_DIV;
      if (req[CHAN_W'(idx)]) begin
        grantIdx = CHAN_W'(idx);
        anyGrant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_tick_arbiter.sv
// Samples the divided-clock lines, timestamps rising edges per channel and
// serialises them round-robin onto one valid/ready event stream.
module div_tick_arbiter
  import div_tick_pkg::*;
#(
  parameter int NB_DIV  = NB_DIV_DEF,
  parameter int STAMP_W = STAMP_W_DEF,
  parameter int CHAN_W  = CHAN_W_DEF
) (
  input  logic               ClkIn,
  input  logic               Reset,
  input  logic [NB_DIV-1:0]  DivIn,
  output logic               EvValid,
  input  logic               EvReady,
  output logic [CHAN_W-1:0]  EvChan,
  output logic [STAMP_W-1:0] EvStamp,
  output logic [NB_DIV-1:0]  Ovf,
  input  logic [NB_DIV-1:0]  OvfClr
);

  logic [NB_DIV-1:0]  divQ, divQQ, rise, pend, grantHit, ovfSet;
  logic [STAMP_W-1:0] stamp;
  logic [STAMP_W-1:0] chStamp [NB_DIV];
  logic [CHAN_W-1:0]  lastPtr, grantIdx;
  logic               anyGrant, slotLoad, doGrant;

  // Both stages reset high so a line already high at release is not an edge.
  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      divQ  <= '1;
      divQQ <= '1;
      stamp <= '0;
    end else begin
      divQ  <= DivIn;
      divQQ <= divQ;
      stamp <= stamp + STAMP_W'(1);
    end
  end

  assign rise     = divQ & ~divQQ;
  assign slotLoad = ~EvValid | EvReady;
  assign doGrant  = slotLoad & anyGrant;

  rr_arbiter #(
    .NB_DIV(NB_DIV),
    .CHAN_W(CHAN_W)
  ) u_arb (
    .req     (pend),
    .lastPtr (lastPtr),
    .grantIdx(grantIdx),
    .anyGrant(anyGrant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NB_DIV; gi++) begin : g_chan
      assign grantHit[gi] = doGrant && (grantIdx == CHAN_W'(gi));
      // A granted channel frees its slot this cycle, so a coinciding edge is not lost.
      assign ovfSet[gi]   = rise[gi] & pend[gi] & ~grantHit[gi];
    end
  endgenerate

  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      pend <= '0;
      for (int i = 0; i < NB_DIV; i++) chStamp[i] <= '0;
    end else begin
      for (int i = 0; i < NB_DIV; i++) begin
        if (rise[i] && (!pend[i] || grantHit[i])) begin
          pend[i]    <= 1'b1;
          chStamp[i] <= stamp;
        end else if (grantHit[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) Ovf <= '0;
    else       Ovf <= ovfSet | (Ovf & ~OvfClr);
  end

  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      EvValid <= 1'b0;
      EvChan  <= '0;
      EvStamp <= '0;
      lastPtr <= CHAN_W'(NB_DIV - 1);
    end else if (doGrant) begin
      EvValid <= 1'b1;
      EvChan  <= grantIdx;
      EvStamp <= chStamp[grantIdx];
      lastPtr <= grantIdx;
    end else if (EvReady) begin
      EvValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_tick_arbiter.sv
// Directed bench for div_tick_arbiter: latency, ordering, backpressure,
// overflow set/clear and a full-bank run against a per-channel stamp scoreboard.
module tb_div_tick_arbiter;
  import div_tick_pkg::*;

  localparam int NB = 24;
  localparam int SW = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] divIn, ovf, ovfClr, prevDrive;
  logic          evValid, evReady;
  logic [CW-1:0] evChan;
  logic [SW-1:0] evStamp;

  int checks  = 0;
  int errors  = 0;
  int edgeCnt = 0;
  int eventsSeen = 0;
  int unsigned expQ [NB][$];

  div_tick_arbiter #(
    .NB_DIV (NB),
    .STAMP_W(SW),
    .CHAN_W (CW)
  ) dut (
    .ClkIn  (clk),
    .Reset  (rst),
    .DivIn  (divIn),
    .EvValid(evValid),
    .EvReady(evReady),
    .EvChan (evChan),
    .EvStamp(evStamp),
    .Ovf    (ovf),
    .OvfClr (ovfClr)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edgeCnt++;
  endtask

  task automatic waitTo(input int e);
    while (edgeCnt < e) tick();
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases just after an edge.
  task automatic resetDut();
    #2;
    rst = 1'b1;
    #1;
    checkValue("async_reset_evvalid", 32'(evValid), 0);
    checkValue("async_reset_ovf", 32'(ovf), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    edgeCnt = 0;
  endtask

  function automatic logic [NB-1:0] bankPattern(input int n);
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = (((n + (i * 13) % 48) % 48) < 24);
    return v;
  endfunction

  task automatic driveBank(input logic [NB-1:0] newV);
    for (int i = 0; i < NB; i++)
      if (newV[i] && !prevDrive[i]) expQ[i].push_back((edgeCnt + 1) % 65536);
    prevDrive = newV;
    divIn = newV;
  endtask

  task automatic observeBank();
    if (evValid) begin
      eventsSeen++;
      if (evChan < CW'(NB) && expQ[evChan].size() > 0)
        checkValue($sformatf("bank_stamp_ch%0d", evChan), 32'(evStamp), expQ[evChan].pop_front());
      else
        checkValue("bank_spurious_event_chan", 32'(evChan), 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    int leftover;
    rst = 1'b1; divIn = '1; ovfClr = '0; evReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    edgeCnt = 0;

    // Lines high through reset release: no events, no overflow.
    for (int c = 0; c < 20; c++) begin
      tick();
      checkValue($sformatf("idle_high_evvalid_e%0d", edgeCnt), 32'(evValid), 0);
    end
    checkValue("idle_high_ovf", 32'(ovf), 0);

    // Single rise on channel 3 sampled at edge 10.
    divIn = '0;
    resetDut();
    waitTo(9);  divIn[3] = 1'b1;
    waitTo(10); checkValue("single_e10_evvalid", 32'(evValid), 0);
    waitTo(11); checkValue("single_e11_evvalid", 32'(evValid), 0);
    waitTo(12);
    checkValue("single_e12_evvalid", 32'(evValid), 1);
    checkValue("single_e12_evchan", 32'(evChan), 3);
    checkValue("single_e12_evstamp", 32'(evStamp), 10);
    waitTo(13); checkValue("single_e13_pulse_end", 32'(evValid), 0);

    // Simultaneous rises on 0, 5, 23, then 0 and 5 after the pointer wraps.
    divIn = '0;
    resetDut();
    waitTo(4); divIn[0] = 1'b1; divIn[5] = 1'b1; divIn[23] = 1'b1;
    waitTo(7);  checkValue("burst_e7_chan", 32'(evChan), 0);  checkValue("burst_e7_stamp", 32'(evStamp), 5);
    waitTo(8);  checkValue("burst_e8_chan", 32'(evChan), 5);  checkValue("burst_e8_stamp", 32'(evStamp), 5);
    waitTo(9);  checkValue("burst_e9_chan", 32'(evChan), 23); checkValue("burst_e9_stamp", 32'(evStamp), 5);
                checkValue("burst_e9_evvalid", 32'(evValid), 1);
    waitTo(10); checkValue("burst_e10_evvalid", 32'(evValid), 0);
    divIn = '0;
    waitTo(12); divIn[0] = 1'b1; divIn[5] = 1'b1;
    waitTo(15); checkValue("wrap_e15_chan", 32'(evChan), 0); checkValue("wrap_e15_stamp", 32'(evStamp), 13);
    waitTo(16); checkValue("wrap_e16_chan", 32'(evChan), 5); checkValue("wrap_e16_stamp", 32'(evStamp), 13);
    waitTo(17); checkValue("wrap_e17_evvalid", 32'(evValid), 0);

    // Backpressure on channel 7: hold, pend, overflow, clear, then drain older stamp.
    divIn = '0;
    resetDut();
    evReady = 1'b0;
    waitTo(2);  divIn[7] = 1'b1;
    waitTo(5);
    checkValue("bp_e5_evvalid", 32'(evValid), 1);
    checkValue("bp_e5_chan", 32'(evChan), 7);
    checkValue("bp_e5_stamp", 32'(evStamp), 3);
    divIn[7] = 1'b0;
    waitTo(7);  divIn[7] = 1'b1;
    waitTo(9);  divIn[7] = 1'b0;
    checkValue("bp_e9_hold", 32'({evValid, evChan, evStamp}), 32'({1'b1, 5'd7, 16'd3}));
    checkValue("bp_e9_ovf", 32'(ovf), 0);
    waitTo(11); divIn[7] = 1'b1;
    waitTo(13);
    checkValue("bp_e13_ovf", 32'(ovf), 32'h80);
    checkValue("bp_e13_hold", 32'({evValid, evChan, evStamp}), 32'({1'b1, 5'd7, 16'd3}));
    waitTo(14); ovfClr[7] = 1'b1;
    waitTo(15); ovfClr = '0;
    checkValue("bp_e15_ovf_cleared", 32'(ovf), 0);
    checkValue("bp_e15_hold", 32'({evValid, evChan, evStamp}), 32'({1'b1, 5'd7, 16'd3}));
    evReady = 1'b1;
    waitTo(16);
    checkValue("bp_e16_chan", 32'(evChan), 7);
    checkValue("bp_e16_stamp", 32'(evStamp), 8);
    checkValue("bp_e16_evvalid", 32'(evValid), 1);

    // Overflow set and clear on channel 2 in the same cycle: set wins.
    divIn = '0;
    resetDut();
    evReady = 1'b0;
    waitTo(2);  divIn[2] = 1'b1;
    waitTo(5);  checkValue("setclr_e5_chan", 32'(evChan), 2); divIn = '0;
    waitTo(7);  divIn[2] = 1'b1;
    waitTo(9);  divIn = '0;
    waitTo(11); divIn[2] = 1'b1;
    waitTo(12); ovfClr[2] = 1'b1;
    waitTo(13); ovfClr = '0;
    checkValue("setclr_e13_ovf", 32'(ovf), 32'h4);
    ovfClr[2] = 1'b1;
    waitTo(14); ovfClr = '0;
    checkValue("setclr_e14_ovf", 32'(ovf), 0);

    // Grant and rise on channel 9 in the same cycle.
    divIn = '0;
    resetDut();
    evReady = 1'b0;
    waitTo(2);  divIn[1] = 1'b1;
    waitTo(5);  checkValue("samecyc_e5_chan", 32'(evChan), 1);
    waitTo(7);  divIn[9] = 1'b1;
    waitTo(9);  divIn[9] = 1'b0;
    waitTo(11); divIn[9] = 1'b1;
    waitTo(12); evReady = 1'b1;
    waitTo(13);
    checkValue("samecyc_e13_chan", 32'(evChan), 9);
    checkValue("samecyc_e13_stamp", 32'(evStamp), 8);
    checkValue("samecyc_e13_ovf", 32'(ovf), 0);
    waitTo(14);
    checkValue("samecyc_e14_evvalid", 32'(evValid), 1);
    checkValue("samecyc_e14_chan", 32'(evChan), 9);
    checkValue("samecyc_e14_stamp", 32'(evStamp), 12);
    waitTo(15); checkValue("samecyc_e15_evvalid", 32'(evValid), 0);

    // Full bank at divide-by-48 with staggered phases.
    prevDrive = '1;
    evReady = 1'b1;
    divIn = bankPattern(0);
    resetDut();
    prevDrive = bankPattern(0);
    for (int c = 0; c < 10000; c++) begin
      tick();
      observeBank();
      driveBank(bankPattern(edgeCnt));
    end
    for (int c = 0; c < 100; c++) begin
      tick();
      observeBank();
    end
    leftover = 0;
    for (int i = 0; i < NB; i++) leftover += expQ[i].size();
    checkValue("bank_unreported_edges", 32'(leftover), 0);
    checkValue("bank_events_enough", 32'(eventsSeen > 4000), 1);
    checkValue("bank_ovf", 32'(ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
